blink_multi: RTL

//  N-channel LED pattern generator; parametrised successor of the single-LED blinker.
//  One shared prescaler produces a tick at TICK_HZ. Each channel runs its own phase counter:
//  per-channel mode, period and duty are written through a valid/ready config port.

---
 rtl/blink_multi_pkg.sv | 14 +
 rtl/blink_multi_channel.sv | 99 +++++++++
 rtl/blink_multi.sv | 78 +++++++
 3 files changed

// File: rtl/blink_multi_pkg.sv
// Shared definitions for the multi-channel LED pattern generator.
// Mode encoding matches the 2-bit cfg_mode field of the config port.
package blink_multi_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

endpackage

// File: rtl/blink_multi_channel.sv
// One LED channel: holds mode/period/duty, runs its phase counter on prescaler
// ticks and drives a registered led/busy pair one clock behind its state.
module blink_channel
  import blink_multi_pkg::*;
#(
  parameter int PERIOD_W = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                wr_en,
  input  logic [MODE_W-1:0]   mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] duty,
  output logic                led,
  output logic                busy
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  mode_e               mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] duty_q, duty_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] pe;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                expire;

  assign pe = (period_q == '0) ? ONE : period_q;
  // A one-shot ends on the tick that would carry phase up to duty; led and busy drop on that same edge.
  assign expire = (mode_q == MODE_ONESHOT) && tick && ((phase_q + ONE) >= duty_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= MODE_OFF;
      period_q <= '0;
      duty_q   <= '0;
      phase_q  <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
    end
  end

  // A config write always wins over a coincident tick.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    if (wr_en) begin
      mode_d   = mode_e'(mode);
      period_d = period;
      duty_d   = duty;
      phase_d  = '0;
    end else begin
      case (mode_q)
        MODE_OFF: phase_d = '0;
        MODE_BLINK: begin
          if (tick) phase_d = (phase_q >= pe - ONE) ? '0 : phase_q + ONE;
        end
        MODE_ONESHOT: begin
          if ((phase_q >= duty_q) || expire) begin
            mode_d  = MODE_OFF;
            phase_d = '0;
          end else if (tick) begin
            phase_d = phase_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d  = 1'b0;
    busy_d = 1'b0;
    case (mode_q)
      MODE_ON:    led_d = 1'b1;
      MODE_BLINK: led_d = (phase_q < duty_q);
      MODE_ONESHOT: begin
        busy_d = (phase_q < duty_q) && !expire;
        led_d  = busy_d;
      end
      default: ;
    endcase
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: rtl/blink_multi.sv
// N-channel LED pattern generator: shared tick prescaler, config decode and
// error flag, plus one blink_channel per LED.
module blink_multi
  import blink_multi_pkg::*;
#(
  parameter int  CLOCK_FREQ = 24_000_000,
  parameter int  TICK_HZ    = 1_000,
  parameter int  CHANNELS   = 4,
  parameter int  PERIOD_W   = 12,
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_duty,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] led
);

  localparam int          DIV      = CLOCK_FREQ / TICK_HZ;
  localparam int          PW       = $clog2(DIV);
  localparam logic [CW:0] CHAN_LIM = CHANNELS[CW:0];

  logic [PW-1:0]       cnt_q, cnt_d;
  logic                tick;
  logic                cfg_ready_q;
  logic                cfg_err_q, cfg_err_d;
  logic                wr;
  logic                chan_ok;
  logic [CHANNELS-1:0] wr_en;

  assign tick  = (cnt_q == PW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + PW'(1);

  // Valid/ready: a write is taken on any edge where cfg_valid and cfg_ready are both high.
  assign wr        = cfg_valid && cfg_ready_q;
  assign chan_ok   = ({1'b0, cfg_chan} < CHAN_LIM);
  assign cfg_err_d = wr && !chan_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign wr_en[i] = wr && (cfg_chan == CW'(i));

    blink_channel #(
      .PERIOD_W(PERIOD_W)
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .tick  (tick),
      .wr_en (wr_en[i]),
      .mode  (cfg_mode),
      .period(cfg_period),
      .duty  (cfg_duty),
      .led   (led[i]),
      .busy  (busy[i])
    );
  end

endmodule
